// File: rtl/fir_tap_mem.sv
// Single-port FIR coefficient/sample RAM with direct addressing and a circular
// delay-line mode (tap-offset reads, zero padding), plus an optional output register.
module fir_tap_mem #(
    parameter int DW    = 16,
    parameter int AW    = 6,
    parameter int DEPTH = 64,
    parameter int OREG  = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CEN,
    input  logic          WEN,
    input  logic          MODE,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] Q,
    output logic          QV,
    output logic          FULL,
    output logic [AW-1:0] HEAD
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LAST_W   = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] DEPTH_LO = AW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] head_next;
    logic [AW:0]   count;
    logic          full;
    logic [AW:0]   a_ext;
    logic [AW:0]   tap_diff;
    logic [IW-1:0] tap_idx;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic          rd_hit;
    logic          wr_hit;
    logic          do_read;
    logic          do_write;
    logic [DW-1:0] s1_q;
    logic          s1_v;

    assign do_read  = !CEN && WEN;
    assign do_write = !CEN && !WEN;

    // Tap offset is taken back from the newest sample; a negative difference is
    // folded by adding DEPTH so non-power-of-two depths wrap correctly.
    always_comb begin
        a_ext     = {1'b0, A};
        tap_diff  = {1'b0, head} - a_ext - (AW+1)'(1);
        tap_idx   = IW'(tap_diff[AW-1:0] + (tap_diff[AW] ? DEPTH_LO : '0));
        head_next = ({1'b0, head} == LAST_W) ? '0 : head + 1'b1;
        if (MODE) begin
            rd_hit = a_ext < count;
            rd_idx = tap_idx;
            wr_hit = 1'b1;
            wr_idx = IW'(head);
        end else begin
            rd_hit = a_ext < DEPTH_W;
            rd_idx = IW'(A);
            wr_hit = rd_hit;
            wr_idx = IW'(A);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && do_write && wr_hit) begin
            mem[wr_idx] <= D;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head  <= '0;
            count <= '0;
            full  <= 1'b0;
        end else if (do_write && MODE) begin
            head <= head_next;
            if (count != DEPTH_W) begin
                count <= count + 1'b1;
            end
            full <= (count >= LAST_W);
        end
    end

    // First read stage; Q only moves when a read completes so it holds between reads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q <= '0;
            s1_v <= 1'b0;
        end else begin
            s1_v <= do_read;
            if (do_read) begin
                s1_q <= rd_hit ? mem[rd_idx] : '0;
            end
        end
    end

    generate
        if (OREG != 0) begin : g_oreg
            logic [DW-1:0] s2_q;
            logic          s2_v;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    s2_q <= '0;
                    s2_v <= 1'b0;
                end else begin
                    s2_v <= s1_v;
                    if (s1_v) begin
                        s2_q <= s1_q;
                    end
                end
            end
            assign Q  = s2_q;
            assign QV = s2_v;
        end else begin : g_noreg
            assign Q  = s1_q;
            assign QV = s1_v;
        end
    endgenerate

    assign FULL = full;
    assign HEAD = head;

endmodule

// File: doc/fir_tap_mem.md
# fir_tap_mem

Parametrised synchronous single-port memory for the FIR datapath, generalising the fixed 64x16 coefficient/sample RAM. Besides plain addressed read/write, it provides a circular delay-line mode: pushes advance an internal head pointer with wrap-around, and reads are addressed by tap offset from the newest sample, returning zero for taps not yet filled. An optional output register adds one pipeline stage for timing closure in the MAC path.

## Interface
- DW, 16, data width in bits
- AW, 6, address / tap-offset width
- DEPTH, 64, number of words; 2 ≤ DEPTH ≤ 2**AW; need not be a power of two
- OREG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
- CLK  in  1  clock; all activity on rising edge
- RST  in  1  synchronous reset, active high
- CEN  in  1  chip enable, active low; 1 = idle
- WEN  in  1  write enable, active low; 0 = write/push, 1 = read (when CEN=0)
- MODE  in  1  0 = direct addressing, 1 = circular delay line
- A  in  AW  direct address (MODE=0) or tap offset, 0 = newest (MODE=1)
- D  in  DW  write data
- Q  out  DW  read data
- QV  out  1  high for one cycle when Q carries a new read result
- FULL  out  1  delay line holds DEPTH samples
- HEAD  out  AW  next circular write location (debug/observability)

## Operation
- Internal state: mem[DEPTH] (not reset), HEAD (0..DEPTH-1), COUNT (0..DEPTH), read pipeline.
- Reset (RST=1 at an edge): HEAD=0, COUNT=0, Q=0, QV=0, FULL=0, all pipeline stages cleared; RST overrides CEN/WEN; mem contents retained.
- CEN=1: no access; Q holds its last value, QV=0 (once the pipeline drains).
- MODE=0, write: mem[A]<=D if A<DEPTH, else ignored. HEAD/COUNT unchanged.
- MODE=0, read: result = mem[A] if A<DEPTH, else 0.
- MODE=1, push (write): mem[HEAD]<=D; HEAD<=(HEAD+1==DEPTH)?0:HEAD+1; COUNT<=min(COUNT+1,DEPTH). Pushing while FULL overwrites the oldest sample; COUNT stays at DEPTH.
- MODE=1, read: if A<COUNT, result = mem[(HEAD-1-A) mod DEPTH]; else result = 0 (zero padding, also covers A≥DEPTH).
- Modulo arithmetic uses AW+1-bit intermediate, with DEPTH added when negative; never relies on power-of-two wrap.
- FULL = (COUNT==DEPTH), registered alongside COUNT.
- MODE may change on any cycle; HEAD/COUNT are never modified by MODE=0 accesses, so direct writes may corrupt delay-line data by design (used for coefficient preload into a separate region).
- Write cycles do not update Q (no write-through); QV=0 for writes.
- One access per cycle; no read/write collision possible.

## Timing
- OREG=0: read with CEN=0,WEN=1 sampled at edge N; Q valid and QV=1 after edge N, until edge N+1.
- OREG=1: same read yields Q/QV after edge N+1. Back-to-back reads give one result per cycle in order.
- Circular read at edge N following push at edge N-1 sees the pushed sample at A=0 (HEAD/COUNT updated at N-1).
- HEAD, COUNT, FULL update at the same edge as the push.
- RST asserted mid-pipeline (OREG=1): in-flight read discarded, QV=0 after the reset edge.
- Q holds value between reads; only QV pulses.

## Test plan
- Direct R/W (DEPTH=64, OREG=0): write 0x0011,0x0022,0x0033 to A=0,3,6; read A=3 -> Q=0x0022 with QV one cycle after read edge; write cycle leaves Q unchanged.
- Out-of-range (DEPTH=48): write 0xBEEF to A=50, read A=50 -> Q=0; mem[2] (A=2) unaffected.
- Delay line fill (DEPTH=8, MODE=1): push 10,20,30; read A=0,1,2,3 -> 30,20,10,0; FULL=0, HEAD=3.
- Wrap-around (DEPTH=8): push 1..11; FULL=1 after 8th push, HEAD=3; read A=0 -> 11, A=7 -> 4; A=8 -> 0.
- Latency (OREG=1): reads A=0,1,2 on consecutive cycles -> Q/QV appear two edges after each, back-to-back, same values as OREG=0.
- Reset mid-operation: after 5 pushes issue read, assert RST next edge -> QV=0, Q=0, HEAD=0, FULL=0; subsequent read A=0 -> 0 (COUNT=0) despite mem retaining data.
